// File: rtl/sim_mem_trace_replay.sv
`default_nettype none
// ============================================================================
// Module   : sim_mem_trace_replay (with trace-parser package)
// Brief    : Per-lane FIFO replay of a memory trace; SIM_MEM_TRACE_STATS_EN adds fire logging/stats.
// Revision : 1.0
// ============================================================================

package sim_mem_trace_replay_pkg;
    typedef struct {
        longint unsigned cycle;
        int              lane;
        bit              is_store;
        longint unsigned addr;
        int              size;
        longint unsigned data;
    } trace_rec_t;

    // Parsed trace records and the parser read position; the position survives replayer reset.
    trace_rec_t trace_q[$];
    int         trace_pos  = 0;
    string      trace_name = "";

    function automatic int memtrace_init(input string filename);
        trace_name = filename;
        return (trace_name.len() > 0) ? 0 : -1;
    endfunction

    function automatic void memtrace_query(
        input  bit              enable,
        input  longint unsigned cycle,
        input  int              lane,
        output bit              valid,
        output longint unsigned addr,
        output bit              is_store,
        output int              size,
        output longint unsigned data,
        output bit              finished
    );
        valid    = 1'b0;
        addr     = '0;
        is_store = 1'b0;
        size     = 0;
        data     = '0;
        if (enable && trace_pos < trace_q.size() && trace_q[trace_pos].lane == lane &&
            trace_q[trace_pos].cycle <= cycle) begin
            valid     = 1'b1;
            addr      = trace_q[trace_pos].addr;
            is_store  = trace_q[trace_pos].is_store;
            size      = trace_q[trace_pos].size;
            data      = trace_q[trace_pos].data;
            trace_pos = trace_pos + 1;
        end
        finished = (trace_pos >= trace_q.size());
    endfunction
endpackage

module sim_mem_trace_replay #(
    parameter string FILENAME   = "undefined",
    parameter int    NUM_LANES  = 4,
    parameter int    ADDR_WIDTH = 64,
    parameter int    DATA_WIDTH = 64,
    parameter int    SIZE_WIDTH = 8,
    parameter int    FIFO_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_LANES-1:0]            req_ready,
    output logic [NUM_LANES-1:0]            req_valid,
    output logic [ADDR_WIDTH*NUM_LANES-1:0] req_address,
    output logic [NUM_LANES-1:0]            req_is_store,
    output logic [SIZE_WIDTH*NUM_LANES-1:0] req_size,
    output logic [DATA_WIDTH*NUM_LANES-1:0] req_data,
    output logic                            finished,
    output logic [63:0]                     trace_cycle,
    output logic [31:0]                     stall_cycles
);
    import sim_mem_trace_replay_pkg::*;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + SIZE_WIDTH + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ENT_W-1:0]     fifo_mem [NUM_LANES][FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr   [NUM_LANES];
    logic [PTR_W-1:0]     wr_ptr   [NUM_LANES];
    logic [CNT_W-1:0]     count    [NUM_LANES];
    logic [NUM_LANES-1:0] lane_full;
    logic [NUM_LANES-1:0] fire;
    logic                 all_empty;
    logic                 advance;
    logic                 init_done;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [ENT_W-1:0] head;
        assign req_valid[g] = (count[g] != '0);
        assign lane_full[g] = (count[g] == CNT_W'(FIFO_DEPTH));
        assign fire[g]      = req_valid[g] & req_ready[g];
        assign head         = req_valid[g] ? fifo_mem[g][rd_ptr[g]] : '0;
        assign req_is_store[g]                                 = head[ENT_W-1];
        assign req_size[SIZE_WIDTH*(g+1)-1 -: SIZE_WIDTH]      = head[ADDR_WIDTH+DATA_WIDTH +: SIZE_WIDTH];
        assign req_address[ADDR_WIDTH*(g+1)-1 -: ADDR_WIDTH]   = head[DATA_WIDTH +: ADDR_WIDTH];
        assign req_data[DATA_WIDTH*(g+1)-1 -: DATA_WIDTH]      = head[DATA_WIDTH-1:0];
    end

    assign all_empty = ~|req_valid;
    // Uses pre-edge occupancy only, so a full lane popped this cycle still stalls trace time.
    assign advance   = (state == ST_RUN) && ~|lane_full;

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT:  state_next = ST_RUN;
            ST_DRAIN: if (all_empty) state_next = ST_DONE;
            default:  state_next = state;
        endcase
    end

    always_ff @(posedge clock) begin : p_replay
        logic            q_valid;
        logic            q_store;
        logic            q_fin;
        logic            any_fin;
        longint unsigned q_addr;
        longint unsigned q_data;
        int              q_size;

        if (!init_done) begin
            void'(memtrace_init(FILENAME));
        end
        init_done <= 1'b1;
        any_fin = 1'b0;

        if (reset) begin
            state        <= ST_INIT;
            trace_cycle  <= '0;
            stall_cycles <= '0;
            finished     <= 1'b0;
            for (int g = 0; g < NUM_LANES; g++) begin
                rd_ptr[g] <= '0;
                wr_ptr[g] <= '0;
                count[g]  <= '0;
            end
        end else begin
            for (int g = 0; g < NUM_LANES; g++) begin
                q_valid = 1'b0;
                q_store = 1'b0;
                q_fin   = 1'b0;
                q_addr  = '0;
                q_data  = '0;
                q_size  = 0;
                if (advance) begin
                    memtrace_query(1'b1, trace_cycle, g, q_valid, q_addr, q_store, q_size, q_data, q_fin);
                    if (q_fin) any_fin = 1'b1;
                end
                if (q_valid) begin
                    fifo_mem[g][wr_ptr[g]] <= {q_store, SIZE_WIDTH'(q_size), ADDR_WIDTH'(q_addr), DATA_WIDTH'(q_data)};
                    wr_ptr[g]              <= wr_ptr[g] + 1'b1;
                end
                if (fire[g]) rd_ptr[g] <= rd_ptr[g] + 1'b1;
                count[g] <= count[g] + CNT_W'(q_valid) - CNT_W'(fire[g]);
            end

            if (advance) begin
                trace_cycle <= trace_cycle + 64'd1;
            end else if (state == ST_RUN && stall_cycles != 32'hFFFF_FFFF) begin
                stall_cycles <= stall_cycles + 32'd1;
            end

            // Records returned alongside the finished flag were already pushed above.
            state <= any_fin ? ST_DRAIN : state_next;
            if (state == ST_DRAIN && state_next == ST_DONE) finished <= 1'b1;
        end
    end

`ifdef SIM_MEM_TRACE_STATS_EN
    logic [63:0]      issued  [NUM_LANES];
    logic [CNT_W-1:0] max_occ [NUM_LANES];

    always_ff @(posedge clock) begin : p_stats
        if (reset) begin
            for (int g = 0; g < NUM_LANES; g++) begin
                issued[g]  <= '0;
                max_occ[g] <= '0;
            end
        end else begin
            for (int g = 0; g < NUM_LANES; g++) begin
                if (fire[g]) begin
                    issued[g] <= issued[g] + 64'd1;
                    $display("trace lane %0d cycle %0d addr %h %s", g, trace_cycle,
                             req_address[ADDR_WIDTH*(g+1)-1 -: ADDR_WIDTH], req_is_store[g] ? "store" : "load");
                end
                if (count[g] > max_occ[g]) max_occ[g] <= count[g];
            end
            if (state == ST_DRAIN && state_next == ST_DONE) begin
                for (int g = 0; g < NUM_LANES; g++) begin
                    $display("trace lane %0d issued %0d max_occupancy %0d", g, issued[g], max_occ[g]);
                end
                $display("trace stall_cycles %0d", stall_cycles);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sim_mem_trace_replay.sv
`default_nettype none
// ============================================================================
// Module   : tb_sim_mem_trace_replay
// Brief    : Directed tables and random traces checked against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_sim_mem_trace_replay;
    import sim_mem_trace_replay_pkg::*;

    localparam int NL    = 4;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int SW    = 8;
    localparam int DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NL-1:0]     req_ready = '0;
    logic [NL-1:0]     req_valid;
    logic [AW*NL-1:0]  req_address;
    logic [NL-1:0]     req_is_store;
    logic [SW*NL-1:0]  req_size;
    logic [DW*NL-1:0]  req_data;
    logic              finished;
    logic [63:0]       trace_cycle;
    logic [31:0]       stall_cycles;

    always #5 clock = ~clock;

    sim_mem_trace_replay #(
        .FILENAME("bench_trace"), .NUM_LANES(NL), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .SIZE_WIDTH(SW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .req_ready(req_ready), .req_valid(req_valid),
        .req_address(req_address), .req_is_store(req_is_store), .req_size(req_size),
        .req_data(req_data), .finished(finished), .trace_cycle(trace_cycle),
        .stall_cycles(stall_cycles)
    );

    typedef struct {
        logic          st;
        logic [SW-1:0] size;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        logic        rdy;
        logic        vld;
        logic [63:0] tc;
        logic [31:0] st;
        logic [63:0] addr;
        logic        fin;
    } vec_t;

    ent_t        mq [NL][$];
    trace_rec_t  recs[$];
    int          mp      = 0;
    int          m_phase = 0;   // 0 init, 1 run, 2 drain, 3 done
    logic [63:0] m_cycle = '0;
    logic [31:0] m_stall = '0;
    logic        m_fin   = 1'b0;
    int          n_cmp   = 0;
    int          n_bad   = 0;
    vec_t        tbl [14];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_rec(input longint unsigned cyc, input int lane, input bit st,
                           input longint unsigned addr, input int size, input longint unsigned data);
        trace_rec_t r;
        r.cycle = cyc; r.lane = lane; r.is_store = st; r.addr = addr; r.size = size; r.data = data;
        trace_q.push_back(r);
        recs.push_back(r);
    endtask

    // Reference behaviour for one clock edge, from pre-edge inputs and occupancies.
    task automatic model_step(input logic rst, input logic [NL-1:0] rdy);
        bit any_full;
        bit none_held;
        ent_t e;
        if (rst) begin
            for (int g = 0; g < NL; g++) mq[g].delete();
            m_cycle = '0; m_stall = '0; m_fin = 1'b0; m_phase = 0;
            return;
        end
        any_full  = 0;
        none_held = 1;
        for (int g = 0; g < NL; g++) begin
            if (mq[g].size() == DEPTH) any_full = 1;
            if (mq[g].size() != 0) none_held = 0;
        end
        for (int g = 0; g < NL; g++)
            if (mq[g].size() != 0 && rdy[g]) void'(mq[g].pop_front());
        case (m_phase)
            0: m_phase = 1;
            1: begin
                if (any_full) begin
                    if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
                end else begin
                    for (int g = 0; g < NL; g++) begin
                        if (mp < recs.size() && recs[mp].lane == g && recs[mp].cycle <= m_cycle) begin
                            e.st = recs[mp].is_store; e.size = SW'(recs[mp].size);
                            e.addr = recs[mp].addr;   e.data = recs[mp].data;
                            mq[g].push_back(e);
                            mp++;
                        end
                    end
                    m_cycle = m_cycle + 1;
                    if (mp >= recs.size()) m_phase = 2;
                end
            end
            2: if (none_held) begin m_phase = 3; m_fin = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        for (int g = 0; g < NL; g++) begin
            logic [191:0] a;
            logic [191:0] e;
            a = {req_valid[g], req_is_store[g], req_size[g*SW +: SW], req_address[g*AW +: AW], req_data[g*DW +: DW]};
            if (mq[g].size() != 0) e = {1'b1, mq[g][0].st, mq[g][0].size, mq[g][0].addr, mq[g][0].data};
            else                   e = '0;
            chk($sformatf("lane%0d_head", g), a, e);
        end
        chk("counters", {finished, stall_cycles, trace_cycle}, {m_fin, m_stall, m_cycle});
    endtask

    task automatic step();
        @(posedge clock);
        model_step(reset, req_ready);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input bit rand_ready);
        for (int i = 0; i < budget; i++) begin
            if (rand_ready) req_ready = NL'($urandom);
            step();
            if (m_phase == 3) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL done_timeout: got no DONE within %0d cycles, required DONE", budget);
    endtask

    task automatic random_segment(input int n);
        int cur;
        int last;
        int inc;
        int lane;
        cur = 0; last = -1;
        for (int i = 0; i < n; i++) begin
            inc = $urandom_range(2, 0);
            if (inc == 0 && last == NL - 1) inc = 1;
            if (inc != 0) begin cur += inc; last = -1; end
            lane = $urandom_range(NL - 1, last + 1);
            last = lane;
            add_rec(longint'(cur), lane, bit'($urandom_range(1, 0)), {$urandom, $urandom},
                    $urandom_range(3, 0), {$urandom, $urandom});
        end
    endtask

    initial begin
        tbl = '{
            '{1'b0, 1'b0, 64'd0, 32'd0, 64'h0,   1'b0},
            '{1'b0, 1'b1, 64'd1, 32'd0, 64'h100, 1'b0},
            '{1'b0, 1'b1, 64'd2, 32'd0, 64'h100, 1'b0},
            '{1'b0, 1'b1, 64'd3, 32'd0, 64'h100, 1'b0},
            '{1'b0, 1'b1, 64'd4, 32'd0, 64'h100, 1'b0},
            '{1'b0, 1'b1, 64'd4, 32'd1, 64'h100, 1'b0},
            '{1'b0, 1'b1, 64'd4, 32'd2, 64'h100, 1'b0},
            '{1'b1, 1'b1, 64'd4, 32'd3, 64'h101, 1'b0},
            '{1'b1, 1'b1, 64'd5, 32'd3, 64'h102, 1'b0},
            '{1'b1, 1'b1, 64'd6, 32'd3, 64'h103, 1'b0},
            '{1'b1, 1'b1, 64'd6, 32'd3, 64'h104, 1'b0},
            '{1'b1, 1'b1, 64'd6, 32'd3, 64'h105, 1'b0},
            '{1'b1, 1'b0, 64'd6, 32'd3, 64'h0,   1'b0},
            '{1'b1, 1'b0, 64'd6, 32'd3, 64'h0,   1'b1}
        };

        // Reset state, then an empty trace.
        reset = 1'b1; req_ready = '0;
        step();
        step();
        chk("reset_state", {req_valid, finished, trace_cycle, stall_cycles}, '0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("empty_no_valid", req_valid, '0);
        end
        chk("empty_finished_clk3", finished, 1);

        // Single load on lane 0.
        add_rec(0, 0, 1'b0, 64'h1000, 2, 0);
        do_reset();
        req_ready = '1;
        step();
        chk("t1_clk1_valid", req_valid, 4'b0000);
        step();
        chk("t1_clk2_valid", req_valid, 4'b0001);
        chk("t1_clk2_req", {req_is_store[0], req_size[SW-1:0], req_address[AW-1:0]}, {1'b0, 8'd2, 64'h1000});
        step();
        chk("t1_fin_early", finished, 0);
        step();
        chk("t1_fin", finished, 1);

        // Lane 1 backpressure: fill, stall, then drain in order.
        for (int i = 0; i < 6; i++) add_rec(i, 1, 1'b1, 64'h100 + i, 3, i);
        do_reset();
        for (int r = 0; r < 14; r++) begin
            req_ready = {2'b00, tbl[r].rdy, 1'b0};
            step();
            chk($sformatf("t2_row%0d", r),
                {req_valid[1], req_is_store[1], req_address[AW +: AW], trace_cycle, stall_cycles, finished},
                {tbl[r].vld, tbl[r].vld, tbl[r].addr, tbl[r].tc, tbl[r].st, tbl[r].fin});
        end

        // Lane 2 request every cycle with ready high.
        for (int i = 0; i < 8; i++) add_rec(i, 2, 1'b0, 64'h2000 + i, 1, 0);
        do_reset();
        req_ready = '1;
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t3_valid_high", req_valid[2], 1);
        end
        chk("t3_no_stall", stall_cycles, 0);
        run_until_done(20, 1'b0);

        // Lane 3 store payload held under backpressure.
        add_rec(0, 3, 1'b1, 64'h3000, 3, 64'hDEAD_BEEF_0123_4567);
        do_reset();
        req_ready = '0;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_store", {req_valid[3], req_is_store[3], req_size[3*SW +: SW], req_data[3*DW +: DW]},
                {1'b1, 1'b1, 8'd3, 64'hDEAD_BEEF_0123_4567});
        end
        req_ready = '1;
        run_until_done(10, 1'b0);

        // Reset with three entries queued; parser resumes at the next record.
        for (int i = 0; i < 10; i++) add_rec(i, 0, 1'b0, 64'h5000 + i, 0, 0);
        do_reset();
        req_ready = '0;
        for (int i = 0; i < 4; i++) step();
        chk("t5_pre_reset", {req_valid, trace_cycle}, {4'b0001, 64'd3});
        reset = 1'b1;
        step();
        chk("t5_after_reset", {req_valid, finished, trace_cycle, stall_cycles}, '0);
        reset = 1'b0;
        req_ready = '1;
        for (int i = 0; i < 10 && !req_valid[0]; i++) step();
        chk("t5_resume_addr", {req_valid[0], req_address[AW-1:0]}, {1'b1, 64'h5003});
        run_until_done(40, 1'b0);

        // Random traces with random per-lane ready.
        for (int s = 0; s < 3; s++) begin
            random_segment(40);
            do_reset();
            run_until_done(600, 1'b1);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
